// File: rtl/dbus_mmio.sv
// dbus_mmio: data-bus slave for a single-cycle rv32i core.
// Decodes core stores/loads into a byte-addressable data RAM and a memory-mapped
// UART transmitter. The transmitter is fed from a TX FIFO so stores never stall.
//
// Ports:
//   clk_i              sole clock, rising edge
//   rst_i              asynchronous, active-high reset
//   dbus_en_i          store byte enables, low-justified (1=SB, 3=SH, 15=SW, 0=none)
//   dbus_write_addr_i  store byte address
//   dbus_read_addr_i   load byte address
//   dbus_write_data_i  store data, low-justified
//   dbus_read_data_o   load data, combinational from dbus_read_addr_i
//   uart_tx_o          8N1 serial output, idle high, registered
//
// Map: RAM at 0 .. RAM_WORDS*4-1, TXDATA (write-only) at 0x8000_0000,
// STATUS at 0x8000_0004 = {count[16:8], overflow[3], busy[2], empty[1], full[0]}.
module dbus_mmio #(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BAUD_DIV   = 868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  dbus_en_i,
  input  logic [31:0] dbus_write_addr_i,
  input  logic [31:0] dbus_read_addr_i,
  input  logic [31:0] dbus_write_data_i,
  output logic [31:0] dbus_read_data_o,
  output logic        uart_tx_o
);

  localparam int unsigned RamAw = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(BAUD_DIV);
  localparam logic [32:0] RamBytes   = 33'(RAM_WORDS) * 33'd4;
  localparam logic [31:0] TxDataAddr = 32'h8000_0000;
  localparam logic [31:0] StatusAddr = 32'h8000_0004;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // ---------------------------------------------------------------- data RAM
  logic [31:0] ram_q [RAM_WORDS];

  logic             ram_wr_hit, ram_rd_hit;
  logic [1:0]       woff, roff;
  logic [RamAw-1:0] widx, ridx;
  logic [3:0]       lane_mask;
  logic [31:0]      lane_data;

  assign woff       = dbus_write_addr_i[1:0];
  assign roff       = dbus_read_addr_i[1:0];
  assign widx       = dbus_write_addr_i[RamAw+1:2];
  assign ridx       = dbus_read_addr_i[RamAw+1:2];
  assign ram_wr_hit = ({1'b0, dbus_write_addr_i} < RamBytes);
  assign ram_rd_hit = ({1'b0, dbus_read_addr_i} < RamBytes);
  // 4-bit context truncates lanes that would spill past the word boundary.
  assign lane_mask  = dbus_en_i << woff;
  assign lane_data  = dbus_write_data_i << {woff, 3'b000};

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (ram_wr_hit) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_mask[l]) begin
          ram_q[widx][8*l +: 8] <= lane_data[8*l +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            full, empty, push_req, push, pop, ovf_clr;

  state_e           state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             baud_last;

  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = (state_q == StIdle) && !empty;
  assign push_req = (dbus_write_addr_i == TxDataAddr) && dbus_en_i[0];
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);
  assign ovf_clr  = (dbus_write_addr_i == StatusAddr) && (dbus_en_i != 4'b0000);

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= dbus_write_data_i[7:0];
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    // Set wins over a same-cycle clear.
    if (push_req && !push) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // ---------------------------------------------------------------- UART FSM
  assign baud_last = (baud_q == BaudW'(BAUD_DIV - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    if (state_q != StIdle) begin
      baud_d = baud_last ? '0 : baud_q + 1'b1;
    end
    // tx_d follows the current state, so the line lags state by one cycle.
    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (pop) begin
          shift_d = fifo_q[rd_ptr_q];
          state_d = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (baud_last) begin
          state_d = StData;
          idx_d   = 3'd0;
        end
      end
      StData: begin
        tx_d = shift_q[idx_q];
        if (baud_last) begin
          if (idx_q == 3'd7) begin
            state_d = StStop;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (baud_last) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign uart_tx_o = tx_q;

  // ---------------------------------------------------------------- read mux
  logic [31:0] status, ram_word;

  assign status   = {15'b0, 9'(count_q), 4'b0, ovf_q, (state_q != StIdle), empty, full};
  assign ram_word = ram_q[ridx];

  always_comb begin
    dbus_read_data_o = 32'h0;
    if (ram_rd_hit) begin
      dbus_read_data_o = ram_word >> {roff, 3'b000};
    end else if (dbus_read_addr_i == StatusAddr) begin
      dbus_read_data_o = status;
    end
  end

endmodule

// File: tb/tb_dbus_mmio.sv
// Testbench for dbus_mmio: table-driven RAM/decode vectors plus hand-written UART
// sequences. Transmitted bytes are checked by a serial monitor against a queue of
// expected bytes pushed when each TXDATA store is driven.
module tb_dbus_mmio;

  localparam int unsigned RamWords  = 1024;
  localparam int unsigned FifoDepth = 4;
  localparam int unsigned BaudDiv   = 4;
  localparam logic [31:0] TxAddr    = 32'h8000_0000;
  localparam logic [31:0] StAddr    = 32'h8000_0004;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  dbus_en_i;
  logic [31:0] dbus_write_addr_i, dbus_read_addr_i, dbus_write_data_i;
  logic [31:0] dbus_read_data_o;
  logic        uart_tx_o;

  dbus_mmio #(
    .RAM_WORDS (RamWords),
    .FIFO_DEPTH(FifoDepth),
    .BAUD_DIV  (BaudDiv)
  ) u_dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .dbus_en_i        (dbus_en_i),
    .dbus_write_addr_i(dbus_write_addr_i),
    .dbus_read_addr_i (dbus_read_addr_i),
    .dbus_write_data_i(dbus_write_data_i),
    .dbus_read_data_o (dbus_read_data_o),
    .uart_tx_o        (uart_tx_o)
  );

  always #5 clk_i = ~clk_i;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];
  longint     start_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    dbus_read_addr_i = StAddr;
    #1;
    while ((dbus_read_data_o[2] || !dbus_read_data_o[1]) && n < 300) begin
      cyc();
      n++;
    end
    check(name, {30'h0, dbus_read_data_o[2:1]}, 32'h1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    wait_idle({name, "_idle"});
  endtask

  // Expected line level m cycles after the edge that pushed a byte into an idle UART.
  function automatic logic tx_expect(input int m, input logic [7:0] b);
    int k;
    if (m < 2 || m > 41) return 1'b1;
    k = (m - 2) / BaudDiv;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Serial monitor: samples mid-bit, aborts a frame cut short by reset.
  initial begin
    forever begin
      logic [7:0] b;
      logic       stop_b;
      logic       aborted;
      @(negedge uart_tx_o);
      if (!rst_i) begin
        start_q.push_back($time);
        aborted = 1'b0;
        #(BaudDiv * 5);
        aborted = aborted | rst_i;
        if (!aborted) check("start_bit", {31'h0, uart_tx_o}, 32'h0);
        for (int i = 0; i < 8; i++) begin
          #(BaudDiv * 10);
          b[i]    = uart_tx_o;
          aborted = aborted | rst_i;
        end
        #(BaudDiv * 10);
        stop_b  = uart_tx_o;
        aborted = aborted | rst_i;
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL frame_unexpected: got byte 0x%02h, expected no frame", b);
          end else begin
            check("frame_byte", {24'h0, b}, {24'h0, exp_q.pop_front()});
          end
          check("stop_bit", {31'h0, stop_b}, 32'h1);
        end
      end
    end
  end

  typedef struct {
    logic [3:0]  en;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [18];

  initial begin
    int busy_cnt;
    int n;

    // Read column sees state before the same row's store commits.
    vecs[0]  = '{4'h0, 32'h0000_0000, 32'h0000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[1]  = '{4'hF, 32'h0000_0100, 32'h1122_3344, StAddr,        32'h0000_0002};
    vecs[2]  = '{4'h1, 32'h0000_0102, 32'hFFFF_FFAA, 32'h0000_0100, 32'h1122_3344};
    vecs[3]  = '{4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0100, 32'h11AA_3344};
    vecs[4]  = '{4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0102, 32'h0000_11AA};
    vecs[5]  = '{4'hF, 32'h0000_0104, 32'h0102_0304, 32'h0000_0101, 32'h0011_AA33};
    vecs[6]  = '{4'h3, 32'h0000_0103, 32'h1234_BEEF, 32'h0000_0104, 32'h0102_0304};
    vecs[7]  = '{4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0100, 32'hEFAA_3344};
    vecs[8]  = '{4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0104, 32'h0102_0304};
    vecs[9]  = '{4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0103, 32'h0000_00EF};
    vecs[10] = '{4'hF, 32'h4000_0000, 32'hDEAD_BEEF, TxAddr,        32'h0000_0000};
    vecs[11] = '{4'h0, 32'h0000_0000, 32'h0000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[12] = '{4'hF, 32'h0000_0000, 32'h1234_5678, 32'h0000_1000, 32'h0000_0000};
    vecs[13] = '{4'hF, 32'h0000_1000, 32'hCAFE_F00D, 32'h0000_0000, 32'h1234_5678};
    vecs[14] = '{4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_1000, 32'h0000_0000};
    vecs[15] = '{4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678};
    vecs[16] = '{4'h3, 32'h0000_0FFE, 32'h0000_CAFE, StAddr,        32'h0000_0002};
    vecs[17] = '{4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0FFE, 32'h0000_CAFE};

    rst_i             = 1'b1;
    dbus_en_i         = 4'h0;
    dbus_write_addr_i = 32'h0;
    dbus_write_data_i = 32'h0;
    dbus_read_addr_i  = StAddr;
    #1;
    check("reset_tx", {31'h0, uart_tx_o}, 32'h1);
    check("reset_status", dbus_read_data_o, 32'h0000_0002);
    cyc();
    cyc();
    rst_i = 1'b0;
    cyc();

    // ---- RAM lanes, boundary drop, decode
    for (int i = 0; i < 18; i++) begin
      dbus_en_i         = vecs[i].en;
      dbus_write_addr_i = vecs[i].waddr;
      dbus_write_data_i = vecs[i].wdata;
      dbus_read_addr_i  = vecs[i].raddr;
      #2;
      check($sformatf("vec%0d_rdata", i), dbus_read_data_o, vecs[i].exp);
      cyc();
    end
    dbus_en_i         = 4'h0;
    dbus_write_addr_i = 32'h0;
    dbus_read_addr_i  = StAddr;

    // ---- Single frame, cycle-accurate line and busy window
    dbus_en_i         = 4'h1;
    dbus_write_addr_i = TxAddr;
    dbus_write_data_i = 32'h0000_0055;
    exp_q.push_back(8'h55);
    cyc();
    dbus_en_i         = 4'h0;
    dbus_write_addr_i = 32'h0;
    check("push_status", dbus_read_data_o, 32'h0000_0100);
    busy_cnt = 0;
    for (int m = 0; m < 50; m++) begin
      check($sformatf("tx55_m%0d", m), {31'h0, uart_tx_o}, {31'h0, tx_expect(m, 8'h55)});
      if (m == 1) check("popped_status", dbus_read_data_o, 32'h0000_0006);
      if (dbus_read_data_o[2]) busy_cnt++;
      cyc();
    end
    check("busy_cycles", busy_cnt, 40);
    wait_drain("frame55", 200);

    // ---- FIFO full and overflow
    start_q.delete();
    for (int i = 0; i < 6; i++) begin
      dbus_en_i         = 4'h1;
      dbus_write_addr_i = TxAddr;
      dbus_write_data_i = 32'hA1 + i;
      if (i < 5) exp_q.push_back(8'hA1 + 8'(i));
      cyc();
    end
    dbus_en_i         = 4'h0;
    dbus_write_addr_i = 32'h0;
    check("overflow_status", dbus_read_data_o, 32'h0000_040D);
    wait_drain("ovf_frames", 400);
    check("ovf_frame_count", start_q.size(), 5);
    for (int i = 1; i < start_q.size(); i++) begin
      check($sformatf("frame_spacing%0d", i), 32'(start_q[i] - start_q[i-1]),
            32'(10 * (10 * BaudDiv + 1)));
    end
    check("ovf_sticky", dbus_read_data_o, 32'h0000_000A);
    dbus_en_i         = 4'hF;
    dbus_write_addr_i = StAddr;
    cyc();
    dbus_en_i         = 4'h0;
    dbus_write_addr_i = 32'h0;
    check("ovf_cleared", dbus_read_data_o, 32'h0000_0002);

    // ---- Push on pop with a full FIFO
    for (int i = 0; i < 5; i++) begin
      dbus_en_i         = 4'h1;
      dbus_write_addr_i = TxAddr;
      dbus_write_data_i = 32'hB1 + i;
      exp_q.push_back(8'hB1 + 8'(i));
      cyc();
    end
    dbus_en_i         = 4'h0;
    dbus_write_addr_i = 32'h0;
    n = 0;
    while (dbus_read_data_o[2] && n < 100) begin
      cyc();
      n++;
    end
    check("full_idle_status", dbus_read_data_o, 32'h0000_0401);
    dbus_en_i         = 4'h1;
    dbus_write_addr_i = TxAddr;
    dbus_write_data_i = 32'h0000_00B6;
    exp_q.push_back(8'hB6);
    cyc();
    dbus_en_i         = 4'h0;
    dbus_write_addr_i = 32'h0;
    check("push_on_pop_status", dbus_read_data_o, 32'h0000_0405);
    wait_drain("pushpop_frames", 600);

    // ---- Reset during data bit 3
    dbus_en_i         = 4'h1;
    dbus_write_addr_i = TxAddr;
    dbus_write_data_i = 32'h0000_00A5;
    exp_q.push_back(8'hA5);
    cyc();
    dbus_en_i         = 4'h0;
    dbus_write_addr_i = 32'h0;
    repeat (19) cyc();
    check("pre_reset_tx", {31'h0, uart_tx_o}, 32'h0);
    rst_i = 1'b1;
    exp_q.delete();
    #1;
    check("async_reset_tx", {31'h0, uart_tx_o}, 32'h1);
    check("async_reset_status", dbus_read_data_o, 32'h0000_0002);
    repeat (5) cyc();
    rst_i = 1'b0;
    repeat (50) cyc();
    check("post_reset_status", dbus_read_data_o, 32'h0000_0002);
    dbus_en_i         = 4'h1;
    dbus_write_addr_i = TxAddr;
    dbus_write_data_i = 32'h0000_003C;
    exp_q.push_back(8'h3C);
    cyc();
    dbus_en_i         = 4'h0;
    dbus_write_addr_i = 32'h0;
    wait_drain("post_reset_frame", 200);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    tests_run++;
    tests_failed++;
    $display("FAIL global_timeout: got time %0t, expected finish earlier", $time);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "timeout");
  end

endmodule
